// File: rtl/core88_pkg.sv
// core88_pkg: shared bus-master definitions (address width, default read latency, DMA state encoding)
package core88_pkg;
  localparam int AW = 20;
  localparam int RD_LAT_DEF = 1;
  typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, DONE} dma_state_t;
endpackage

// File: rtl/dma88.sv
// dma88: byte copy/fill DMA engine for the 20-bit core88 bus
//   clock, reset (async, active-high); locked = bus grant (0 stalls the engine)
//   address/data/wreq = memory write port, bus = read data arriving RD_LAT clocks after address
//   start/mode/src/dst/len/fill = transfer request, latched in IDLE
//   busy/done/count = transfer status, count = bytes remaining
module dma88
  import core88_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          locked,
  output logic [AW-1:0] address,
  input  logic [7:0]    bus,
  output logic [7:0]    data,
  output logic          wreq,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [15:0]   len,
  input  logic [7:0]    fill,
  output logic          busy,
  output logic          done,
  output logic [15:0]   count
);
  localparam logic [1:0] LAT = 2'(RD_LAT);
  dma_state_t state, state_nx;
  logic [AW-1:0] src_cur, dst_cur;
  logic [1:0] lat;
  logic [7:0] byte_r, fill_r;
  logic mode_r;
  // Only the bus-driving states freeze on a lost grant; IDLE and DONE never touch the bus.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : len == '0 ? DONE : mode ? WR : RD;
      RD:      state_nx = locked ? RDWAIT : RD;
      RDWAIT:  state_nx = locked && lat == 2'd1 ? WR : RDWAIT;
      WR:      state_nx = !locked ? WR : count == 16'd1 ? DONE : mode_r ? WR : RD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign busy    = state == RD || state == RDWAIT || state == WR;
  assign done    = state == DONE;
  assign wreq    = state == WR && locked;
  assign address = state == RD || state == RDWAIT ? src_cur : dst_cur;
  assign data    = mode_r ? fill_r : byte_r;
  // A stall in RDWAIT reloads the latency counter so the captured byte is
  // always RD_LAT granted clocks after the held address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      src_cur <= '0;
      dst_cur <= '0;
      count   <= '0;
      lat     <= '0;
      byte_r  <= '0;
      fill_r  <= '0;
      mode_r  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        src_cur <= src;
        dst_cur <= dst;
        count   <= len;
        mode_r  <= mode;
        fill_r  <= fill;
      end
      if (state == RD && locked) lat <= LAT;
      if (state == RDWAIT) lat <= locked ? lat - 2'd1 : LAT;
      if (state == RDWAIT && locked && lat == 2'd1) byte_r <= bus;
      if (wreq) begin
        src_cur <= src_cur + AW'(1);
        dst_cur <= dst_cur + AW'(1);
        count   <= count - 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_dma88.sv
// tb_dma88: randomized and directed checks of dma88 against a byte-level transfer model
module tb_dma88;
  localparam int LAT = 1;
  typedef struct packed {
    logic [19:0] a;
    logic [7:0]  d;
  } wr_t;
  logic clock = 1'b0, reset = 1'b1, locked = 1'b1, start = 1'b0, mode = 1'b0;
  logic wreq, busy, done;
  logic [19:0] address, src = '0, dst = '0;
  logic [7:0] bus, data, fill = '0;
  logic [15:0] len = '0, count;
  dma88 #(.RD_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .locked(locked), .address(address), .bus(bus),
    .data(data), .wreq(wreq), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill(fill), .busy(busy), .done(done), .count(count)
  );
  always #5 clock = ~clock;
  logic [7:0] mem [0:1048575];
  logic [7:0] ref_m [0:1048575];
  logic ld_en = 1'b0;
  logic [19:0] ld_a = '0;
  logic [7:0] ld_d = '0, bus_q;
  assign bus = bus_q;
  always @(posedge clock) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (wreq) mem[address] <= data;
    bus_q <= mem[address];
  end
  int errors = 0, checks = 0;
  wr_t q[$];
  bit open = 1'b0;
  int cyc = 0, exp_done = 0, last_done_cyc = 0, nwr = 0, ndone = 0;
  logic [15:0] exp_cnt = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // Model: while writes remain the engine is busy and each wreq must carry the
  // next planned byte; the first cycle with nothing left is the done pulse.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (open) begin
        cyc++;
        if (q.size() > 0) begin
          chk("busy", busy, 1);
          chk("done_early", done, 0);
          chk("count", count, exp_cnt);
          if (!locked) chk("wreq_stalled", wreq, 0);
          if (wreq) begin
            chk("wr_addr", address, q[0].a);
            chk("wr_data", data, q[0].d);
            ref_m[q[0].a] = q[0].d;
            void'(q.pop_front());
            exp_cnt--;
            nwr++;
          end
        end else begin
          chk("done", done, 1);
          chk("busy_at_done", busy, 0);
          chk("wreq_at_done", wreq, 0);
          if (exp_done != 0) chk("done_cycle", cyc, exp_done);
          last_done_cyc = cyc;
          ndone++;
          open = 1'b0;
        end
      end else begin
        chk("idle_done", done, 0);
        chk("idle_wreq", wreq, 0);
      end
    end
  end
  task automatic poke(input logic [19:0] a, input logic [7:0] v);
    ref_m[a] = v;
    ld_a = a;
    ld_d = v;
    ld_en = 1'b1;
    @(posedge clock);
    #1 ld_en = 1'b0;
  endtask
  task automatic poke_rand(input logic [19:0] a, input int n);
    for (int i = 0; i < n; i++) poke(a + 20'(i), 8'($urandom));
  endtask
  task automatic begin_xfer(input logic m, input logic [19:0] s, input logic [19:0] dd,
                            input logic [15:0] n, input logic [7:0] f, input bit rnd);
    logic [7:0] tmp [logic [19:0]];
    logic [7:0] v;
    logic [19:0] sa, da;
    for (int i = 0; i < int'(n); i++) begin
      sa = s + 20'(i);
      da = dd + 20'(i);
      v = m ? f : (tmp.exists(sa) ? tmp[sa] : ref_m[sa]);
      tmp[da] = v;
      q.push_back('{a: da, d: v});
    end
    mode = m;
    src = s;
    dst = dd;
    len = n;
    fill = f;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    exp_cnt = n;
    cyc = 0;
    exp_done = rnd ? 0 : (m ? int'(n) + 1 : int'(n) * (LAT + 2) + 1);
    open = 1'b1;
  endtask
  task automatic finish_xfer(input bit rnd);
    for (int k = 0; k < 3000 && open; k++) begin
      @(posedge clock);
      #1;
      if (rnd) locked = $urandom_range(0, 3) != 0;
    end
    locked = 1'b1;
    if (open) begin
      checks++;
      errors++;
      $display("FAIL timeout: transfer still open, %0d writes outstanding", q.size());
      open = 1'b0;
      q.delete();
    end
  endtask
  task automatic xfer(input logic m, input logic [19:0] s, input logic [19:0] dd,
                      input logic [15:0] n, input logic [7:0] f, input bit rnd);
    begin_xfer(m, s, dd, n, f, rnd);
    finish_xfer(rnd);
  endtask
  task automatic check_img(input string name, input logic [19:0] base, input int n);
    for (int i = 0; i < n; i++) chk(name, mem[base + 20'(i)], ref_m[base + 20'(i)]);
  endtask
  task automatic wait_wreq();
    for (int k = 0; k < 50 && !wreq; k++) begin
      @(posedge clock);
      #1;
    end
    chk("wreq_anchor", wreq, 1);
  endtask
  initial begin
    int n0, d0;
    logic [7:0] o0, keep;
    logic m;
    logic [15:0] n;
    logic [19:0] s, d;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_address", address, 0);
    chk("rst_data", data, 0);
    chk("rst_wreq", wreq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    poke(20'hF0000, 8'h11);
    poke(20'hF0001, 8'h22);
    poke(20'hF0002, 8'h33);
    poke(20'hF0003, 8'h44);
    n0 = nwr;
    xfer(1'b0, 20'hF0000, 20'h00100, 16'd4, 8'h00, 1'b0);
    chk("copy_b0", mem[20'h00100], 8'h11);
    chk("copy_b1", mem[20'h00101], 8'h22);
    chk("copy_b2", mem[20'h00102], 8'h33);
    chk("copy_b3", mem[20'h00103], 8'h44);
    chk("copy_done_cyc", last_done_cyc, 13);
    chk("copy_nwr", nwr - n0, 4);
    chk("copy_count_end", count, 0);
    n0 = nwr;
    xfer(1'b1, 20'h00000, 20'hFFFFE, 16'd4, 8'hAA, 1'b0);
    chk("fill_FFFFE", mem[20'hFFFFE], 8'hAA);
    chk("fill_FFFFF", mem[20'hFFFFF], 8'hAA);
    chk("fill_00000", mem[20'h00000], 8'hAA);
    chk("fill_00001", mem[20'h00001], 8'hAA);
    chk("fill_done_cyc", last_done_cyc, 5);
    chk("fill_nwr", nwr - n0, 4);
    n0 = nwr;
    d0 = ndone;
    xfer(1'b0, 20'h12345, 20'h54321, 16'd0, 8'h00, 1'b0);
    chk("len0_done_cyc", last_done_cyc, 1);
    chk("len0_nwr", nwr - n0, 0);
    chk("len0_ndone", ndone - d0, 1);
    poke_rand(20'h20000, 6);
    n0 = nwr;
    begin_xfer(1'b0, 20'h20000, 20'h30000, 16'd6, 8'h00, 1'b0);
    exp_done = 1 + 6 * (LAT + 2) + 10;
    wait_wreq();
    repeat (2) @(posedge clock);
    #1 locked = 1'b0;
    repeat (5) @(posedge clock);
    #1 locked = 1'b1;
    wait_wreq();
    locked = 1'b0;
    repeat (5) @(posedge clock);
    #1 locked = 1'b1;
    finish_xfer(1'b0);
    check_img("stall_img", 20'h30000, 6);
    chk("stall_nwr", nwr - n0, 6);
    poke_rand(20'h40000, 8);
    o0 = ref_m[20'h40000];
    xfer(1'b0, 20'h40000, 20'h40002, 16'd6, 8'h00, 1'b0);
    check_img("overlap_img", 20'h40000, 8);
    chk("overlap_pin", mem[20'h40006], o0);
    poke_rand(20'h50000, 5);
    poke_rand(20'h52000, 3);
    d0 = ndone;
    begin_xfer(1'b0, 20'h50000, 20'h51000, 16'd5, 8'h00, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    mode = 1'b1;
    dst = 20'h52000;
    len = 16'd3;
    fill = 8'h5A;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    finish_xfer(1'b0);
    check_img("busy_start_dst", 20'h51000, 5);
    check_img("busy_start_other", 20'h52000, 3);
    chk("busy_start_ndone", ndone - d0, 1);
    poke_rand(20'h60000, 8);
    poke_rand(20'h61000, 8);
    keep = ref_m[20'h61002];
    n0 = nwr;
    d0 = ndone;
    begin_xfer(1'b0, 20'h60000, 20'h61000, 16'd8, 8'h00, 1'b0);
    for (int k = 0; k < 100 && nwr < n0 + 2; k++) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("abort_wreq", wreq, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    open = 1'b0;
    q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check_img("abort_img", 20'h61000, 8);
    chk("abort_untouched", mem[20'h61002], keep);
    chk("abort_nwr", nwr - n0, 2);
    chk("abort_ndone", ndone - d0, 0);
    chk("abort_count", count, 0);
    for (int it = 0; it < 20; it++) begin
      m = 1'($urandom_range(0, 1));
      n = 16'($urandom_range(0, 10));
      s = 20'($urandom);
      d = $urandom_range(0, 1) != 0 ? s + 20'($urandom_range(0, 12)) : 20'($urandom);
      if (!m) poke_rand(s, int'(n));
      n0 = nwr;
      xfer(m, s, d, n, 8'($urandom), 1'b1);
      check_img("rand_img", d, int'(n));
      chk("rand_nwr", nwr - n0, 32'(n));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
